// File: rtl/fifo_wptr_full_pkg.sv
// Shared constants and pointer-code helpers for the async FIFO pointer blocks.
// The helpers work on 32-bit values; callers cast to their own pointer width.
package fifo_wptr_full_pkg;

  localparam int A_LENGTH_DEFAULT = 3;
  localparam int PTR_W = A_LENGTH_DEFAULT + 1;

  function automatic logic [31:0] bin2gray(input logic [31:0] bin);
    return bin ^ (bin >> 1);
  endfunction

  function automatic logic [31:0] gray2bin(input logic [31:0] gray);
    logic [31:0] bin;
    bin[31] = gray[31];
    for (int i = 30; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
    return bin;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a bus that is Gray-coded in its source domain.
module sync_2ff #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] q1;

  always_ff @(posedge clk) begin
    if (rst) begin
      q1 <= '0;
      q  <= '0;
    end else begin
      q1 <= d;
      q  <= q1;
    end
  end

endmodule

// File: rtl/fifo_wptr_full.sv
// Write-side pointer and full flag for the async FIFO (write clock domain only).
// Optional almost_full output is built when FIFO_ALMOST_FULL_EN is defined.
module fifo_wptr_full #(
  parameter int A_LENGTH  = fifo_wptr_full_pkg::A_LENGTH_DEFAULT,
  parameter int AF_MARGIN = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wr_en,
  input  logic [A_LENGTH:0]   rd_ptr_gray,
  output logic [A_LENGTH-1:0] wr_addr,
  output logic [A_LENGTH:0]   wr_ptr_gray,
  output logic [A_LENGTH:0]   wr_ptr_bin,
  output logic                wr_accept,
  output logic                full,
  output logic                wr_overflow
`ifdef FIFO_ALMOST_FULL_EN
  ,
  output logic                almost_full
`endif
);

  import fifo_wptr_full_pkg::*;

  localparam int PW = A_LENGTH + 1;

  logic [PW-1:0] rq2;
  logic [PW-1:0] bin_next;
  logic [PW-1:0] gray_next;
  logic [PW-1:0] full_target;

  sync_2ff #(.W(PW)) u_rsync (
    .clk (clk),
    .rst (rst),
    .d   (rd_ptr_gray),
    .q   (rq2)
  );

  // Handshake: a write happens in a cycle where wr_en=1 and full=0; wr_accept
  // is that qualified strobe and is the only signal the RAM should write on.
  assign wr_accept = wr_en & ~full;
  assign bin_next  = wr_ptr_bin + PW'(wr_accept);
  assign gray_next = PW'(bin2gray(32'(bin_next)));
  assign wr_addr   = wr_ptr_bin[A_LENGTH-1:0];

  // Writer is one full lap ahead of the synchronised reader: top two Gray bits differ.
  assign full_target = {~rq2[A_LENGTH:A_LENGTH-1], rq2[A_LENGTH-2:0]};

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_bin  <= '0;
      wr_ptr_gray <= '0;
      full        <= 1'b0;
      wr_overflow <= 1'b0;
    end else begin
      wr_ptr_bin  <= bin_next;
      wr_ptr_gray <= gray_next;
      full        <= (gray_next == full_target);
      wr_overflow <= wr_en & full;
    end
  end

`ifdef FIFO_ALMOST_FULL_EN
  localparam logic [PW-1:0] AF_LEVEL = PW'((1 << A_LENGTH) - AF_MARGIN);

  logic [PW-1:0] rbin;
  logic [PW-1:0] fill;

  assign rbin = PW'(gray2bin(32'(rq2)));
  assign fill = bin_next - rbin;

  always_ff @(posedge clk) begin
    if (rst) begin
      almost_full <= 1'b0;
    end else begin
      almost_full <= (fill >= AF_LEVEL);
    end
  end
`endif

endmodule

// File: tb/tb_fifo_wptr_full.sv
// Self-checking bench for fifo_wptr_full (A_LENGTH=3, depth 8, 4-bit pointers).
// Also checks almost_full when built with FIFO_ALMOST_FULL_EN.
module tb_fifo_wptr_full;

  localparam int AL    = 3;
  localparam int AF    = 1;
  localparam int DEPTH = 1 << AL;
  localparam int MODV  = 2 * DEPTH;

  logic          clk;
  logic          rst;
  logic          wr_en;
  logic [AL:0]   rd_ptr_gray;
  logic [AL-1:0] wr_addr;
  logic [AL:0]   wr_ptr_gray;
  logic [AL:0]   wr_ptr_bin;
  logic          wr_accept;
  logic          full;
  logic          wr_overflow;
`ifdef FIFO_ALMOST_FULL_EN
  logic          almost_full;
`endif

  fifo_wptr_full #(.A_LENGTH(AL), .AF_MARGIN(AF)) dut (
    .clk         (clk),
    .rst         (rst),
    .wr_en       (wr_en),
    .rd_ptr_gray (rd_ptr_gray),
    .wr_addr     (wr_addr),
    .wr_ptr_gray (wr_ptr_gray),
    .wr_ptr_bin  (wr_ptr_bin),
    .wr_accept   (wr_accept),
    .full        (full),
    .wr_overflow (wr_overflow)
`ifdef FIFO_ALMOST_FULL_EN
    ,
    .almost_full (almost_full)
`endif
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  // Counts writes and compares against the reader's position as seen
  // through the synchroniser delay, using occupancy arithmetic.
  int   m_w;        // writes accepted, mod 2*DEPTH
  logic m_full;
  logic m_ovf;
  logic m_af;
  int   seen1, seen2; // read count after one / two write-clock edges

  function automatic int to_gray(input int b);
    return (b ^ (b >> 1)) & (MODV - 1);
  endfunction

  task automatic model_reset();
    m_w = 0; m_full = 0; m_ovf = 0; m_af = 0; seen1 = 0; seen2 = 0;
  endtask

  task automatic model_edge(input logic r, input logic we, input int rd);
    int acc, new_w, occ;
    if (r) begin
      model_reset();
    end else begin
      acc    = (we && !m_full) ? 1 : 0;
      m_ovf  = we && m_full;
      new_w  = (m_w + acc) % MODV;
      occ    = (new_w - seen2 + MODV) % MODV;
      m_full = (occ == DEPTH);
      m_af   = (occ >= DEPTH - AF);
      seen2  = seen1;
      seen1  = rd;
      m_w    = new_w;
    end
  endtask

  // ---------------- driver: one cycle, with checks ----------------
  task automatic step(input logic r, input logic we, input int rd);
    rst         = r;
    wr_en       = we;
    rd_ptr_gray = (AL+1)'(to_gray(rd));
    #1;
    chk("wr_accept", int'(wr_accept), (we && !m_full) ? 1 : 0);
    @(posedge clk);
    model_edge(r, we, rd);
    @(negedge clk);
    chk("wr_ptr_bin",  int'(wr_ptr_bin),  m_w);
    chk("wr_ptr_gray", int'(wr_ptr_gray), to_gray(m_w));
    chk("wr_addr",     int'(wr_addr),     m_w % DEPTH);
    chk("full",        int'(full),        int'(m_full));
    chk("wr_overflow", int'(wr_overflow), int'(m_ovf));
`ifdef FIFO_ALMOST_FULL_EN
    chk("almost_full", int'(almost_full), int'(m_af));
`endif
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic rst;
    logic we;
    int   rd;
    int   exp_bin;
    logic exp_full;
    logic exp_ovf;
  } vec_t;

  vec_t tbl[14];

  initial begin
    int rd;
    int rd_prob;

    // reset, fill 8, overflow twice, idle while full
    tbl[0]  = '{1'b1, 1'b0, 0, 0, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 1'b1, 0, 0, 1'b0, 1'b0};
    for (int i = 0; i < 8; i++)
      tbl[2+i] = '{1'b0, 1'b1, 0, i + 1, (i == 7), 1'b0};
    tbl[10] = '{1'b0, 1'b1, 0, 8, 1'b1, 1'b1};
    tbl[11] = '{1'b0, 1'b1, 0, 8, 1'b1, 1'b1};
    tbl[12] = '{1'b0, 1'b0, 0, 8, 1'b1, 1'b0};
    tbl[13] = '{1'b0, 1'b0, 0, 8, 1'b1, 1'b0};

    rst = 1'b1; wr_en = 1'b0; rd_ptr_gray = '0;
    @(negedge clk);
    model_reset();

    for (int i = 0; i < 14; i++) begin
      step(tbl[i].rst, tbl[i].we, tbl[i].rd);
      chk("tbl_bin",  int'(wr_ptr_bin),  tbl[i].exp_bin);
      chk("tbl_full", int'(full),        int'(tbl[i].exp_full));
      chk("tbl_ovf",  int'(wr_overflow), int'(tbl[i].exp_ovf));
`ifdef FIFO_ALMOST_FULL_EN
      if (i == 8) chk("tbl_af_after_7th", int'(almost_full), 1);
`endif
    end
    chk("full_gray_1100", int'(wr_ptr_gray), 12);
    chk("full_addr_000",  int'(wr_addr),     0);

    // drain release: reader advances one slot, full clears on the 3rd edge
    step(1'b0, 1'b0, 1);
    chk("drain_edge1_full", int'(full), 1);
    step(1'b0, 1'b0, 1);
    chk("drain_edge2_full", int'(full), 1);
    step(1'b0, 1'b0, 1);
    chk("drain_edge3_full", int'(full), 0);
    step(1'b0, 1'b1, 1);
    chk("drain_next_bin",  int'(wr_ptr_bin),  9);
    chk("drain_next_gray", int'(wr_ptr_gray), 13);

    // wrap: 16 writes with the reader two entries behind
    step(1'b1, 1'b0, 0);
    for (int k = 0; k < 16; k++) begin
      rd = (k >= 2) ? k - 2 : 0;
      step(1'b0, 1'b1, rd);
      chk("wrap_no_full", int'(full), 0);
    end
    chk("wrap_gray_0000", int'(wr_ptr_gray), 0);

    // reset in the middle of a fill, with a write pending
    step(1'b1, 1'b0, 0);
    for (int k = 0; k < 5; k++) step(1'b0, 1'b1, 0);
    chk("midfill_bin5", int'(wr_ptr_bin), 5);
    step(1'b1, 1'b1, 0);
    chk("midfill_rst_bin",  int'(wr_ptr_bin), 0);
    chk("midfill_rst_full", int'(full),       0);

    // randomized traffic; the reader never passes the writer
    rd = 0;
    rd_prob = 2;
    for (int c = 0; c < 3000; c++) begin
      logic r, we;
      if (c % 250 == 0) rd_prob = $urandom_range(1, 4);
      r  = ($urandom_range(0, 99) == 0);
      we = ($urandom_range(0, 3) != 0);
      if (r) rd = 0;
      else if (((m_w - rd + MODV) % MODV) != 0 && $urandom_range(0, 4) < rd_prob)
        rd = (rd + 1) % MODV;
      step(r, we, rd);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
